// File: rtl/wb_segment_loader.sv
`default_nettype none
// ============================================================================
// Module   : wb_segment_loader
// Purpose  : Parses block/length/payload/checksum segments from a byte stream
//            and writes the payload into RAM over Wishbone classic writes,
//            holding the CPU in reset and owning the RAM bus while loading.
// Revision : 1.0 - initial release
// ============================================================================
module wb_segment_loader #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int BLOCK_SHIFT = 9,
   parameter int BIG_ENDIAN  = 1,
   parameter int CHECKSUM_EN = 1,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_start,
   input  logic                    i_abort,
   output logic                    o_byte_req,
   input  logic                    i_byte_valid,
   input  logic [7:0]              i_byte_data,
   output logic                    o_wb_cyc,
   output logic                    o_wb_stb,
   output logic                    o_wb_we,
   output logic [DATA_WIDTH/8-1:0] o_wb_sel,
   output logic [ADDR_WIDTH-1:0]   o_wb_adr,
   output logic [DATA_WIDTH-1:0]   o_wb_dat,
   input  logic                    i_wb_ack,
   input  logic                    i_wb_err,
   output logic                    o_cpu_rst,
   output logic                    o_mux,
   output logic                    o_done,
   output logic                    o_err,
   output logic [1:0]              o_err_code,
   output logic [3:0]              o_state
);

   localparam int C_NB     = DATA_WIDTH / 8;
   localparam int C_LANE_W = $clog2(C_NB);
   localparam int C_TO_W   = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_HDR_BLK  = 4'd1,
      S_HDR_LEN  = 4'd2,
      S_PAYLOAD  = 4'd3,
      S_WB_WRITE = 4'd4,
      S_TRAILER  = 4'd5,
      S_DONE     = 4'd6,
      S_ERROR    = 4'd7
   } state_t;

   state_t                state_q, state_d;
   logic [31:0]           blk_q, blk_d;
   logic [31:0]           len_q, len_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [1:0]            hdr_q, hdr_d;
   logic [C_LANE_W-1:0]   lane_q, lane_d;
   logic [ADDR_WIDTH-1:0] word_q, word_d;
   logic [7:0]            sum_q, sum_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [C_NB-1:0]       sel_q, sel_d;
   logic [C_TO_W-1:0]     to_q, to_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;

   logic [C_LANE_W-1:0]   w_lane;
   logic                  w_wb;

   // Physical lane for the next payload byte depends on byte order.
   assign w_lane = (BIG_ENDIAN != 0) ? (C_LANE_W'(C_NB - 1) - lane_q) : lane_q;
   assign w_wb   = (state_q == S_WB_WRITE);

   assign o_byte_req = (state_q == S_HDR_BLK) || (state_q == S_HDR_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_TRAILER);
   assign o_wb_cyc   = w_wb;
   assign o_wb_stb   = w_wb;
   assign o_wb_we    = w_wb;
   assign o_wb_sel   = w_wb ? sel_q : '0;
   assign o_wb_dat   = w_wb ? dat_q : '0;
   assign o_wb_adr   = w_wb ? ((ADDR_WIDTH'(blk_q) << BLOCK_SHIFT) + (word_q << C_LANE_W)) : '0;
   assign o_cpu_rst  = (state_q != S_IDLE) && (state_q != S_DONE);
   assign o_mux      = o_cpu_rst && (state_q != S_ERROR);
   assign o_done     = done_q;
   assign o_err      = err_q;
   assign o_err_code = code_q;
   assign o_state    = state_q;

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         blk_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         hdr_q   <= '0;
         lane_q  <= '0;
         word_q  <= '0;
         sum_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         to_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= '0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         hdr_q   <= hdr_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         sum_q   <= sum_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         to_q    <= to_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   // Next-state and datapath updates; abort overrides everything but keeps status.
   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      hdr_d   = hdr_q;
      lane_d  = lane_q;
      word_d  = word_q;
      sum_d   = sum_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      to_d    = to_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      if (i_abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hdr_d   = '0;
         lane_d  = '0;
         word_d  = '0;
         sum_d   = '0;
         dat_d   = '0;
         sel_d   = '0;
         to_d    = '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (i_start) begin
                  state_d = S_HDR_BLK;
                  hdr_d   = '0;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  code_d  = '0;
               end
            end
            S_HDR_BLK: begin
               if (i_byte_valid) begin
                  blk_d = {blk_q[23:0], i_byte_data};
                  hdr_d = hdr_q + 2'd1;
                  if (hdr_q == 2'd3) begin
                     if (blk_d == 32'hFFFF_FFFF) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = S_HDR_LEN;
                     end
                  end
               end
            end
            S_HDR_LEN: begin
               if (i_byte_valid) begin
                  len_d = {len_q[23:0], i_byte_data};
                  hdr_d = hdr_q + 2'd1;
                  if (hdr_q == 2'd3) begin
                     word_d = '0;
                     lane_d = '0;
                     cnt_d  = '0;
                     sum_d  = '0;
                     dat_d  = '0;
                     sel_d  = '0;
                     if (len_d != 32'd0)      state_d = S_PAYLOAD;
                     else if (CHECKSUM_EN != 0) state_d = S_TRAILER;
                     else                     state_d = S_HDR_BLK;
                  end
               end
            end
            S_PAYLOAD: begin
               if (i_byte_valid) begin
                  for (int i = 0; i < C_NB; i++) begin
                     if (w_lane == C_LANE_W'(i)) begin
                        dat_d[i*8 +: 8] = i_byte_data;
                        sel_d[i]        = 1'b1;
                     end
                  end
                  cnt_d  = cnt_q + 32'd1;
                  sum_d  = sum_q + i_byte_data;
                  lane_d = lane_q + C_LANE_W'(1);
                  if ((lane_q == C_LANE_W'(C_NB - 1)) || (cnt_d == len_q)) begin
                     state_d = S_WB_WRITE;
                     to_d    = '0;
                  end
               end
            end
            S_WB_WRITE: begin
               if (i_wb_err) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = 2'd2;
               end else if (i_wb_ack) begin
                  word_d = word_q + ADDR_WIDTH'(1);
                  lane_d = '0;
                  dat_d  = '0;
                  sel_d  = '0;
                  if (cnt_q != len_q)        state_d = S_PAYLOAD;
                  else if (CHECKSUM_EN != 0) state_d = S_TRAILER;
                  else                       state_d = S_HDR_BLK;
               end else if (to_q == C_TO_W'(ACK_TIMEOUT - 1)) begin
                  state_d = S_ERROR;
                  err_d   = 1'b1;
                  code_d  = 2'd3;
               end else begin
                  to_d = to_q + C_TO_W'(1);
               end
            end
            S_TRAILER: begin
               if (i_byte_valid) begin
                  if (i_byte_data == sum_q) begin
                     state_d = S_HDR_BLK;
                     hdr_d   = '0;
                  end else begin
                     state_d = S_ERROR;
                     err_d   = 1'b1;
                     code_d  = 2'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_segment_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_segment_loader
// Purpose  : Directed self-checking bench for wb_segment_loader (32-bit
//            big-endian and 64-bit little-endian instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_segment_loader;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic byte_valid = 1'b0;
   logic [7:0] byte_data = 8'h00;
   logic use64 = 1'b0;
   logic ack_en = 1'b1;
   logic err_en = 1'b0;
   logic wb_ack, wb_err;

   int tests = 0;
   int fails = 0;

   logic        req32, cyc32, stb32, we32, cpu32, mux32, done32, err32;
   logic [3:0]  sel32;
   logic [31:0] adr32, dat32;
   logic [1:0]  code32;
   logic [3:0]  st32;
   logic        req64, cyc64, stb64, we64, cpu64, mux64, done64, err64;
   logic [7:0]  sel64;
   logic [31:0] adr64;
   logic [63:0] dat64;
   logic [1:0]  code64;
   logic [3:0]  st64;

   logic [31:0] wr_adr[$];
   logic [63:0] wr_dat[$];
   logic [7:0]  wr_sel[$];

   logic        req, cyc, stb;
   logic [31:0] adr;
   logic [63:0] dat;
   logic [7:0]  sel;

   assign req = use64 ? req64 : req32;
   assign cyc = use64 ? cyc64 : cyc32;
   assign stb = use64 ? stb64 : stb32;
   assign adr = use64 ? adr64 : adr32;
   assign dat = use64 ? dat64 : {32'h0, dat32};
   assign sel = use64 ? sel64 : {4'h0, sel32};

   always #5 clk = ~clk;

   wb_segment_loader #(.DATA_WIDTH(32), .BIG_ENDIAN(1)) dut32 (
      .clk(clk), .reset(reset), .i_start(start && !use64), .i_abort(abort),
      .o_byte_req(req32), .i_byte_valid(byte_valid && !use64), .i_byte_data(byte_data),
      .o_wb_cyc(cyc32), .o_wb_stb(stb32), .o_wb_we(we32), .o_wb_sel(sel32),
      .o_wb_adr(adr32), .o_wb_dat(dat32), .i_wb_ack(wb_ack && !use64), .i_wb_err(wb_err && !use64),
      .o_cpu_rst(cpu32), .o_mux(mux32), .o_done(done32), .o_err(err32),
      .o_err_code(code32), .o_state(st32));

   wb_segment_loader #(.DATA_WIDTH(64), .BIG_ENDIAN(0)) dut64 (
      .clk(clk), .reset(reset), .i_start(start && use64), .i_abort(abort),
      .o_byte_req(req64), .i_byte_valid(byte_valid && use64), .i_byte_data(byte_data),
      .o_wb_cyc(cyc64), .o_wb_stb(stb64), .o_wb_we(we64), .o_wb_sel(sel64),
      .o_wb_adr(adr64), .o_wb_dat(dat64), .i_wb_ack(wb_ack && use64), .i_wb_err(wb_err && use64),
      .o_cpu_rst(cpu64), .o_mux(mux64), .o_done(done64), .o_err(err64),
      .o_err_code(code64), .o_state(st64));

   // Wishbone slave: answers one cycle after the strobe and logs acknowledged writes.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
      end else begin
         wb_ack <= 1'b0;
         wb_err <= 1'b0;
         if (cyc && stb && !wb_ack && !wb_err) begin
            if (err_en) begin
               wb_err <= 1'b1;
            end else if (ack_en) begin
               wb_ack <= 1'b1;
               wr_adr.push_back(adr);
               wr_dat.push_back(dat);
               wr_sel.push_back(sel);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      while (!req && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         tests++; fails++;
         $display("FAIL byte_req_wait: no request for byte %02h within 200 cycles", b);
      end
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_adr.delete();
      wr_dat.delete();
      wr_sel.delete();
   endtask

   // Segment at block 2 with bytes 11..88 (first n of them) followed by trailer.
   task automatic send_seg32(input int n, input logic [7:0] trailer);
      logic [7:0] pl [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      send_word(32'h0000_0002);
      send_word(n);
      for (int i = 0; i < n; i++) send_byte(pl[i]);
      send_byte(trailer);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++; if (st32 !== 4'd0) begin fails++; $display("FAIL reset_state got %0d want 0", st32); end
      tests++; if ({cyc32, stb32, we32, req32} !== 4'b0000) begin fails++; $display("FAIL reset_bus got %b want 0000", {cyc32, stb32, we32, req32}); end
      tests++; if ({cpu32, mux32, done32, err32} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl got %b want 0000", {cpu32, mux32, done32, err32}); end
      tests++; if (code32 !== 2'd0) begin fails++; $display("FAIL reset_code got %0d want 0", code32); end
   endtask

   task automatic test_full_words();
      clear_log();
      pulse_start();
      tests++; if ({st32, cpu32, mux32} !== {4'd1, 1'b1, 1'b1}) begin fails++; $display("FAIL start_ctrl got st=%0d cpu=%b mux=%b want 1 1 1", st32, cpu32, mux32); end
      send_seg32(8, 8'h64);    // 0x11*(1+..+8) = 0x264 -> 0x64
      send_word(32'hFFFF_FFFF);
      tests++; if (wr_adr.size() !== 2) begin fails++; $display("FAIL full_count got %0d want 2", wr_adr.size()); end
      if (wr_adr.size() >= 2) begin
         tests++; if ({wr_adr[0], wr_dat[0][31:0], wr_sel[0]} !== {32'h400, 32'h1122_3344, 8'h0F}) begin fails++; $display("FAIL full_w0 got %h %h %h want 400 11223344 0f", wr_adr[0], wr_dat[0], wr_sel[0]); end
         tests++; if ({wr_adr[1], wr_dat[1][31:0], wr_sel[1]} !== {32'h404, 32'h5566_7788, 8'h0F}) begin fails++; $display("FAIL full_w1 got %h %h %h want 404 55667788 0f", wr_adr[1], wr_dat[1], wr_sel[1]); end
      end
      tests++; if ({st32, done32, cpu32, mux32, err32} !== {4'd6, 4'b1000}) begin fails++; $display("FAIL full_done got st=%0d done=%b cpu=%b mux=%b err=%b want 6 1 0 0 0", st32, done32, cpu32, mux32, err32); end
   endtask

   task automatic test_partial_word();
      clear_log();
      pulse_start();
      tests++; if (done32 !== 1'b0) begin fails++; $display("FAIL restart_clears_done got %b want 0", done32); end
      send_seg32(6, 8'h65);    // 0x11*(1+..+6) = 0x165 -> 0x65
      send_word(32'hFFFF_FFFF);
      tests++; if (wr_adr.size() !== 2) begin fails++; $display("FAIL part_count got %0d want 2", wr_adr.size()); end
      if (wr_adr.size() >= 2) begin
         tests++; if ({wr_adr[0], wr_dat[0][31:0], wr_sel[0]} !== {32'h400, 32'h1122_3344, 8'h0F}) begin fails++; $display("FAIL part_w0 got %h %h %h want 400 11223344 0f", wr_adr[0], wr_dat[0], wr_sel[0]); end
         tests++; if ({wr_adr[1], wr_dat[1][31:0], wr_sel[1]} !== {32'h404, 32'h5566_0000, 8'h0C}) begin fails++; $display("FAIL part_w1 got %h %h %h want 404 55660000 0c", wr_adr[1], wr_dat[1], wr_sel[1]); end
      end
      tests++; if ({st32, done32} !== {4'd6, 1'b1}) begin fails++; $display("FAIL part_done got st=%0d done=%b want 6 1", st32, done32); end
   endtask

   task automatic test_bad_checksum();
      clear_log();
      pulse_start();
      send_seg32(8, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      tests++; if (wr_adr.size() !== 2) begin fails++; $display("FAIL cks_count got %0d want 2", wr_adr.size()); end
      tests++; if ({st32, err32, code32, cpu32, mux32, req32} !== {4'd7, 1'b1, 2'd1, 3'b100}) begin fails++; $display("FAIL cks_err got st=%0d err=%b code=%0d cpu=%b mux=%b req=%b want 7 1 1 1 0 0", st32, err32, code32, cpu32, mux32, req32); end
   endtask

   task automatic test_wide_le();
      use64 = 1'b1;
      clear_log();
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'd8);
      for (int i = 1; i <= 8; i++) send_byte(8'(i));
      send_byte(8'h24);         // 1+..+8 = 36
      send_word(32'hFFFF_FFFF);
      tests++; if (wr_adr.size() !== 1) begin fails++; $display("FAIL w64_count got %0d want 1", wr_adr.size()); end
      if (wr_adr.size() >= 1) begin
         tests++; if ({wr_adr[0], wr_dat[0], wr_sel[0]} !== {32'h400, 64'h0807_0605_0403_0201, 8'hFF}) begin fails++; $display("FAIL w64_w0 got %h %h %h want 400 0807060504030201 ff", wr_adr[0], wr_dat[0], wr_sel[0]); end
      end
      tests++; if ({st64, done64, cpu64} !== {4'd6, 1'b1, 1'b0}) begin fails++; $display("FAIL w64_done got st=%0d done=%b cpu=%b want 6 1 0", st64, done64, cpu64); end
      use64 = 1'b0;
   endtask

   task automatic test_timeout();
      ack_en = 1'b0;
      pulse_start();
      tests++; if ({err32, code32} !== 3'b000) begin fails++; $display("FAIL restart_clears_err got err=%b code=%0d want 0 0", err32, code32); end
      send_word(32'h0000_0002);
      send_word(32'd8);
      send_word(32'h1122_3344);
      repeat (1022) @(posedge clk);
      #1;
      tests++; if ({st32, cyc32, req32} !== {4'd4, 1'b1, 1'b0}) begin fails++; $display("FAIL to_waiting got st=%0d cyc=%b req=%b want 4 1 0", st32, cyc32, req32); end
      @(posedge clk);
      #1;
      tests++; if ({st32, err32, code32, cyc32} !== {4'd7, 1'b1, 2'd3, 1'b0}) begin fails++; $display("FAIL to_err got st=%0d err=%b code=%0d cyc=%b want 7 1 3 0", st32, err32, code32, cyc32); end
      ack_en = 1'b1;
   endtask

   task automatic test_bus_err();
      int n = 0;
      err_en = 1'b1;
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'd8);
      send_word(32'h1122_3344);
      while (st32 !== 4'd7 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      tests++; if ({st32, err32, code32, cpu32} !== {4'd7, 1'b1, 2'd2, 1'b1}) begin fails++; $display("FAIL buserr got st=%0d err=%b code=%0d cpu=%b want 7 1 2 1", st32, err32, code32, cpu32); end
      err_en = 1'b0;
   endtask

   task automatic test_abort_restart();
      clear_log();
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'd8);
      send_byte(8'hAA);
      send_byte(8'hBB);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      tests++; if ({st32, cyc32, mux32, cpu32, req32} !== {4'd0, 4'b0000}) begin fails++; $display("FAIL abort got st=%0d cyc=%b mux=%b cpu=%b req=%b want 0 0 0 0 0", st32, cyc32, mux32, cpu32, req32); end
      pulse_start();
      send_seg32(8, 8'h64);
      send_word(32'hFFFF_FFFF);
      tests++; if (wr_adr.size() !== 2) begin fails++; $display("FAIL reload_count got %0d want 2", wr_adr.size()); end
      if (wr_adr.size() >= 2) begin
         tests++; if ({wr_dat[0][31:0], wr_sel[0], wr_dat[1][31:0]} !== {32'h1122_3344, 8'h0F, 32'h5566_7788}) begin fails++; $display("FAIL reload_data got %h/%h %h want 11223344/0f 55667788", wr_dat[0], wr_sel[0], wr_dat[1]); end
      end
      tests++; if (done32 !== 1'b1) begin fails++; $display("FAIL reload_done got %b want 1", done32); end
   endtask

   task automatic test_reset_mid_write();
      ack_en = 1'b0;
      pulse_start();
      send_word(32'h0000_0002);
      send_word(32'd8);
      send_word(32'h1122_3344);
      #2;
      tests++; if (cyc32 !== 1'b1) begin fails++; $display("FAIL rst_pre_cyc got %b want 1", cyc32); end
      reset = 1'b1;
      #1;
      tests++; if ({cyc32, stb32, st32, done32, err32} !== {2'b00, 4'd0, 2'b00}) begin fails++; $display("FAIL rst_async got cyc=%b stb=%b st=%0d done=%b err=%b want 0 0 0 0 0", cyc32, stb32, st32, done32, err32); end
      @(negedge clk);
      reset = 1'b0;
      ack_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_full_words();
      test_partial_word();
      test_bad_checksum();
      test_wide_le();
      test_timeout();
      test_bus_err();
      test_abort_restart();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
